// File: rtl/output_devices_pkg.sv
// output_devices_pkg: shared defaults, entry layout and drain-state encodings.
package output_devices_pkg;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_NUM_SHADOW = 8;
  localparam int ENTRY_W = 40;
  typedef struct packed {
    logic [7:0]  address;
    logic [31:0] value;
  } entry_t;
  typedef enum logic [1:0] {EMPTY = 2'd0, ACTIVE = 2'd1, FULL = 2'd2} state_t;
endpackage

// File: rtl/output_fifo.sv
// output_fifo: generic synchronous FIFO with registered count, full and empty.
module output_fifo #(
  parameter int W = 40,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/output_devices.sv
// output_devices: buffers stage-3 output writes, drains them to the device bus, keeps shadows.
module output_devices
  import output_devices_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int NUM_SHADOW = DEF_NUM_SHADOW,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int SW = $clog2(NUM_SHADOW)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          output_is_write,
  input  logic [7:0]    output_address,
  input  logic [31:0]   output_value,
  output logic          output_full,
  output logic          dev_valid,
  output logic [7:0]    dev_address,
  output logic [31:0]   dev_value,
  input  logic          dev_ready,
  input  logic [7:0]    shadow_address,
  output logic [31:0]   shadow_value,
  output logic [CW-1:0] pending_count,
  output logic [7:0]    dropped_count
);
  localparam logic [7:0] NS = 8'(NUM_SHADOW);
  logic [31:0] shadow [NUM_SHADOW];
  logic fifo_full, fifo_empty, push, pop;
  entry_t head;
  state_t state, state_next;
  assign push = output_is_write && !fifo_full;
  assign pop = dev_ready && !fifo_empty;
  output_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({output_address, output_value}),
    .dout(head),
    .count(pending_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  always_ff @(posedge clk)
    if (reset) state <= EMPTY;
    else state <= state_next;
  always_comb begin
    state_next = state == EMPTY ? (push ? ACTIVE : EMPTY) :
                 state == FULL ? (pop ? ACTIVE : FULL) :
                 (push && !pop && pending_count == CW'(DEPTH-1)) ? FULL :
                 (pop && !push && pending_count == CW'(1)) ? EMPTY : ACTIVE;
  end
  // head is masked so the bus reads zero whenever nothing is buffered
  always_comb begin
    output_full = state == FULL;
    dev_valid = state != EMPTY;
    dev_address = dev_valid ? head.address : '0;
    dev_value = dev_valid ? head.value : '0;
  end
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < NUM_SHADOW; i++) shadow[i] <= '0;
    else if (push && output_address < NS) shadow[output_address[SW-1:0]] <= output_value;
  assign shadow_value = shadow_address < NS ? shadow[shadow_address[SW-1:0]] : '0;
  always_ff @(posedge clk)
    if (reset) dropped_count <= '0;
    else if (output_is_write && output_full && dropped_count != 8'hff) dropped_count <= dropped_count + 1'b1;
endmodule

// File: tb/tb_output_devices.sv
// tb_output_devices: directed and random stimulus against a queue-based reference model.
module tb_output_devices;
  localparam int D = 4;
  localparam int NS = 8;
  logic clk = 0, reset = 1, output_is_write = 0, dev_ready = 0;
  logic [7:0] output_address = 0, shadow_address = 0;
  logic [31:0] output_value = 0;
  logic output_full, dev_valid;
  logic [7:0] dev_address, dropped_count;
  logic [31:0] dev_value, shadow_value;
  logic [2:0] pending_count;
  int checks = 0, fails = 0;
  logic [39:0] q[$];
  logic [31:0] sh [NS];
  int drops = 0;
  output_devices dut (
    .clk(clk), .reset(reset), .output_is_write(output_is_write),
    .output_address(output_address), .output_value(output_value),
    .output_full(output_full), .dev_valid(dev_valid), .dev_address(dev_address),
    .dev_value(dev_value), .dev_ready(dev_ready), .shadow_address(shadow_address),
    .shadow_value(shadow_value), .pending_count(pending_count), .dropped_count(dropped_count)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic check_all();
    logic [39:0] h;
    h = q.size() != 0 ? q[0] : 40'h0;
    chk("dev_valid", 32'(dev_valid), 32'(q.size() != 0));
    chk("dev_address", 32'(dev_address), 32'(h[39:32]));
    chk("dev_value", dev_value, h[31:0]);
    chk("pending_count", 32'(pending_count), 32'(q.size()));
    chk("output_full", 32'(output_full), 32'(q.size() == D));
    chk("dropped_count", 32'(dropped_count), 32'(drops));
    chk("shadow_value", shadow_value, shadow_address < NS ? sh[shadow_address[2:0]] : 32'h0);
  endtask
  task automatic cyc(bit rst, bit w, int a, int v, bit r, int s);
    bit accept, popd;
    reset = rst; output_is_write = w; output_address = 8'(a);
    output_value = 32'(v); dev_ready = r; shadow_address = 8'(s);
    if (rst) begin
      q.delete();
      for (int i = 0; i < NS; i++) sh[i] = 0;
      drops = 0;
    end else begin
      accept = w && q.size() < D;
      popd = r && q.size() > 0;
      if (popd) void'(q.pop_front());
      if (accept) begin
        q.push_back({a[7:0], v[31:0]});
        if (a < NS) sh[a] = v;
      end else if (w && drops < 255) drops++;
    end
    @(negedge clk);
    check_all();
  endtask
  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 0, 1, 0);
    for (int s = 0; s < 8; s++) cyc(0, 0, 0, 0, 1, s);
    cyc(0, 1, 15, 99, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 3, 97, 1, 3);
    cyc(0, 0, 0, 0, 1, 3);
    cyc(0, 1, 9, 55, 1, 9);
    cyc(0, 0, 0, 0, 1, 9);
    for (int i = 1; i <= 5; i++) cyc(0, 1, 20, i, 0, 3);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 3);
    for (int i = 0; i < 4; i++) cyc(0, 1, 21, 40 + i, 0, 0);
    cyc(0, 1, 21, 77, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, i % 2 == 0, 30, 100 + i / 2, i % 2 == 1, 0);
    cyc(0, 1, 5, 200, 0, 5);
    cyc(0, 1, 6, 201, 0, 6);
    cyc(1, 1, 7, 202, 0, 5);
    cyc(0, 0, 0, 0, 0, 5);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15),
          $urandom, $urandom_range(0, 1), $urandom_range(0, 11));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/output_devices.md
Name: output_devices

Overview:
- Responder end of the stage-3 output-write interface: accepts strobed {address, value} writes issued by the execute stage and buffers them in a small FIFO.
- Drains the FIFO to the downstream device bus using a valid/ready handshake.
- Keeps a shadow register per low device address so the core and bench can read back the last value written.
- Asserts a stall flag when the buffer is full, so the core holds the write.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- NUM_SHADOW, 8, number of shadow registers, covering device addresses 0..NUM_SHADOW-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- output_is_write  in  1  write strobe from stage 3; one write per cycle while high.
- output_address  in  8  device address of the write.
- output_value  in  32  data of the write.
- output_full  out  1  FIFO full; stage 3 must hold the write (stall).
- dev_valid  out  1  head entry present on the device bus.
- dev_address  out  8  head entry address.
- dev_value  out  32  head entry data.
- dev_ready  in  1  device accepts the head entry this cycle.
- shadow_address  in  8  read-back select.
- shadow_value  out  32  last value written to shadow_address; 0 if the address is >= NUM_SHADOW.
- pending_count  out  log2(DEPTH)+1  entries currently buffered.
- dropped_count  out  8  writes rejected while full; saturates at 255.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - FIFO pointers = 0, pending_count = 0, output_full = 0, dev_valid = 0.
  - dev_address = 0, dev_value = 0, all shadow registers = 0, dropped_count = 0.
  - Reset mid-transfer discards all buffered entries, even if the device has a transfer in flight.
- Push:
  - Accepted when output_is_write = 1 and output_full = 0 at the clock edge.
  - The entry is written at the tail and the write pointer increments modulo DEPTH.
- Full and drops:
  - output_full = (pending_count == DEPTH), derived from registered state only.
  - A write arriving while full is rejected even if a pop happens in the same cycle; there is no pass-through.
  - Each rejected write increments dropped_count, saturating at 255.
- Pop:
  - Occurs when dev_valid = 1 and dev_ready = 1; the read pointer increments modulo DEPTH.
  - dev_valid = (pending_count != 0).
  - dev_address and dev_value show the head entry and stay stable while dev_valid = 1 and dev_ready = 0.
- Simultaneous push and pop (not full): pending_count is unchanged and both pointers advance.
- Latency:
  - A write into an empty FIFO appears on dev_valid and dev_* one cycle after acceptance.
  - There is no combinational path from output_is_write to any dev_* output.
- Ordering: strictly FIFO; entries reach the device in acceptance order, including across pointer wrap.
- Shadow registers:
  - On an accepted push with output_address < NUM_SHADOW, that shadow register is loaded with output_value.
  - The new value is visible on shadow_value the next cycle; shadow_value is a combinational read of the register array.
  - Rejected writes do not update shadows.
- Drain state machine (registered):
  - EMPTY: count = 0. A push moves to ACTIVE.
  - ACTIVE: 0 < count < DEPTH. If count would reach DEPTH, move to FULL; if a pop leaves count = 0 with no push, move to EMPTY.
  - FULL: count = DEPTH. A pop moves to ACTIVE.
  - The state encoding must match pending_count at all times.
- Width: pending_count holds values 0..DEPTH inclusive.

Decomposition:
- Shared package/include: DEPTH and NUM_SHADOW defaults, the 40-bit entry layout {address[39:32], value[31:0]}, and the state encodings EMPTY=0, ACTIVE=1, FULL=2.
- One sub-module, output_fifo: a generic synchronous FIFO with push/pop, count, full and empty.
- output_devices wraps output_fifo and adds the shadow registers, the drop counter and the state register.

Test Plan:
- Reset then idle, dev_ready = 1 → dev_valid = 0, output_full = 0, pending_count = 0, shadow_value = 0 for shadow_address 0..7.
- Single write addr = 15, value = 99 with dev_ready = 0 → next cycle dev_valid = 1, dev_address = 15, dev_value = 99. Hold dev_ready = 0 for 3 cycles → outputs stable. Raise dev_ready → dev_valid = 0 the following cycle.
- Write addr = 3, value = 97 → next cycle shadow_address = 3 gives shadow_value = 97. Write addr = 9 → shadow_address = 9 gives 0.
- With dev_ready = 0, write values 1..5 back-to-back → output_full = 1 after the 4th write, the 5th is rejected, dropped_count = 1. Drain → device receives 1, 2, 3, 4 in order.
- Fill to 4, then in one cycle assert dev_ready = 1 with a new write → write rejected, dropped_count increments, pending_count = 3.
- Stream 10 writes with dev_ready toggling every cycle (pointer wrap) → all 10 values arrive in order and dropped_count = 0. Then assert reset mid-stream with 2 entries pending → next cycle pending_count = 0, dev_valid = 0.
